// File: rtl/o_coef_seq_upd.sv
// o_coef_seq_upd: lane-shared sequential rescale coefficient c = exp(m_old-m_new)*l_old/l_new per tile row
module o_coef_seq_upd #(
  parameter int D_W    = 8,
  parameter int TIL    = 16,
  parameter int LANES  = 4,
  parameter int C_FRAC = 5,
  parameter int E_FRAC = 6,
  parameter int QB     = C_FRAC + 2
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_START,
  input  logic             I_FIRST,
  input  logic [2*D_W-1:0] I_LI_OLD [TIL],
  input  logic [D_W-1:0]   I_MI_OLD [TIL],
  input  logic [2*D_W-1:0] I_LI_NEW [TIL],
  input  logic [D_W-1:0]   I_MI_NEW [TIL],
  output logic             O_BUSY,
  output logic             O_VLD,
  output logic [D_W-1:0]   O_COEFFICIENT [TIL]
);
  localparam int G  = TIL / LANES;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int CW = QB > 1 ? $clog2(QB) : 1;
  localparam int IW = TIL > 1 ? $clog2(TIL) : 1;
  localparam int RW = 2 * D_W + QB;
  localparam int PW = D_W + QB;

  typedef enum logic [2:0] {IDLE, CLEAR, DIV, MUL, DONE} state_t;

  state_t           state_q;
  logic [GW-1:0]    grp_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, vld_q;
  logic [2*D_W-1:0] li_old_q [TIL];
  logic [2*D_W-1:0] li_new_q [TIL];
  logic [D_W-1:0]   mi_old_q [TIL];
  logic [D_W-1:0]   mi_new_q [TIL];
  logic [D_W-1:0]   coef_q [TIL];
  logic [RW-1:0]    rem_q [LANES];
  logic [QB-1:0]    quo_q [LANES];
  logic [RW-1:0]    rem_d [LANES];
  logic             bit_d [LANES];
  logic [D_W-1:0]   coef_d [LANES];

  // round(2^E_FRAC * exp(x)) for integer x <= 0, via a 16-bit fixed-point table of exp(-k)
  function automatic logic [D_W-1:0] exp_x(input logic signed [D_W-1:0] x);
    int c;
    case (-int'(x))
      0:  c = 65536;
      1:  c = 24109;
      2:  c = 8869;
      3:  c = 3263;
      4:  c = 1200;
      5:  c = 442;
      6:  c = 162;
      7:  c = 60;
      8:  c = 22;
      9:  c = 8;
      10: c = 3;
      11: c = 1;
      default: c = 0;
    endcase
    return D_W'(((2 ** E_FRAC) * c + 32768) >> 16);
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0]         idx;
    logic [RW-1:0]         num, sh;
    logic                  ovf;
    logic [QB-1:0]         q;
    logic [D_W:0]          diff;
    logic signed [D_W-1:0] d;
    logic [D_W-1:0]        e;
    logic [PW-1:0]         p, r;
    assign idx = IW'(int'(grp_q) * LANES + l);
    assign num = RW'({li_old_q[idx], C_FRAC'(0)});
    assign sh = RW'(li_new_q[idx]) << cnt_q;
    assign rem_d[l] = rem_q[l] >= sh ? rem_q[l] - sh : rem_q[l];
    assign bit_d[l] = rem_q[l] >= sh;
    assign ovf = li_new_q[idx] == '0 || num >= (RW'(li_new_q[idx]) << QB);
    assign q = ovf ? '1 : quo_q[l];
    assign diff = {mi_old_q[idx][D_W-1], mi_old_q[idx]} - {mi_new_q[idx][D_W-1], mi_new_q[idx]};
    // non-negative differences clamp to 0; below the signed range saturate to the minimum
    assign d = !diff[D_W] ? '0 : !diff[D_W-1] ? {1'b1, {(D_W-1){1'b0}}} : diff[D_W-1:0];
    assign e = exp_x(d);
    assign p = PW'(e) * PW'(q);
    assign r = (p + PW'(2 ** (E_FRAC - 1))) >> E_FRAC;
    assign coef_d[l] = r > PW'(2 ** (D_W - 1) - 1) ? D_W'(2 ** (D_W - 1) - 1) : r[D_W-1:0];
  end

  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      state_q <= IDLE;
      grp_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      vld_q <= 1'b0;
      for (int i = 0; i < TIL; i++) begin
        li_old_q[i] <= '0;
        li_new_q[i] <= '0;
        mi_old_q[i] <= '0;
        mi_new_q[i] <= '0;
        coef_q[i] <= '0;
      end
      for (int l = 0; l < LANES; l++) begin
        rem_q[l] <= '0;
        quo_q[l] <= '0;
      end
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: if (I_START) begin
          state_q <= I_FIRST ? CLEAR : DIV;
          busy_q <= 1'b1;
          grp_q <= '0;
          cnt_q <= CW'(QB - 1);
          for (int i = 0; i < TIL; i++) begin
            li_old_q[i] <= I_LI_OLD[i];
            li_new_q[i] <= I_LI_NEW[i];
            mi_old_q[i] <= I_MI_OLD[i];
            mi_new_q[i] <= I_MI_NEW[i];
          end
          for (int l = 0; l < LANES; l++) begin
            rem_q[l] <= RW'({I_LI_OLD[l], C_FRAC'(0)});
            quo_q[l] <= '0;
          end
        end
        DIV: begin
          for (int l = 0; l < LANES; l++) begin
            rem_q[l] <= rem_d[l];
            quo_q[l] <= {quo_q[l][QB-2:0], bit_d[l]};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= MUL;
        end
        MUL: begin
          for (int l = 0; l < LANES; l++) begin
            coef_q[IW'(int'(grp_q) * LANES + l)] <= coef_d[l];
            rem_q[l] <= RW'({li_old_q[IW'((int'(grp_q) + 1) * LANES + l)], C_FRAC'(0)});
            quo_q[l] <= '0;
          end
          if (grp_q == GW'(G - 1)) begin
            state_q <= DONE;
            vld_q <= 1'b1;
          end else begin
            state_q <= DIV;
            grp_q <= grp_q + 1'b1;
            cnt_q <= CW'(QB - 1);
          end
        end
        CLEAR: begin
          for (int i = 0; i < TIL; i++) coef_q[i] <= '0;
          state_q <= DONE;
          vld_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign O_BUSY = busy_q;
  assign O_VLD = vld_q;
  assign O_COEFFICIENT = coef_q;
endmodule

// File: tb/tb_o_coef_seq_upd.sv
// tb_o_coef_seq_upd: scoreboard bench for the sequential rescale coefficient unit
module tb_o_coef_seq_upd;
  localparam int TIL = 16;
  localparam int N_NORM = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, first = 1'b0;
  logic [15:0] li_old [TIL];
  logic [15:0] li_new [TIL];
  logic [7:0] mi_old [TIL];
  logic [7:0] mi_new [TIL];
  logic busy, vld;
  logic [7:0] coef [TIL];
  int errors = 0, checks = 0, cyc = 0;

  typedef struct {
    logic [8*TIL-1:0] c;
    int at;
  } exp_t;
  exp_t sb[$];

  o_coef_seq_upd dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_FIRST(first),
    .I_LI_OLD(li_old), .I_MI_OLD(mi_old), .I_LI_NEW(li_new), .I_MI_NEW(mi_new),
    .O_BUSY(busy), .O_VLD(vld), .O_COEFFICIENT(coef)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, want);
    end
  endtask

  function automatic int model(input int lo, input int mo, input int ln, input int mn);
    int q, d, e, r;
    q = ln == 0 ? 127 : (lo * 32) / ln;
    if (q > 127) q = 127;
    d = mo - mn;
    if (d > 0) d = 0;
    if (d < -128) d = -128;
    e = $rtoi($floor(64.0 * $exp(real'(d)) + 0.5));
    r = (e * q + 32) / 64;
    return r > 127 ? 127 : r;
  endfunction

  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n && vld) begin
      if (sb.size() == 0) check("unexpected_vld", 1, 0);
      else begin
        x = sb.pop_front();
        check("vld_latency", cyc, x.at);
        for (int i = 0; i < TIL; i++) check($sformatf("coef[%0d]", i), coef[i], x.c[8*i+:8]);
      end
    end
  end

  task automatic fill(input int lo, input int ln, input int mo, input int mn);
    for (int i = 0; i < TIL; i++) begin
      li_old[i] = 16'(lo);
      li_new[i] = 16'(ln);
      mi_old[i] = 8'(mo);
      mi_new[i] = 8'(mn);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < TIL; i++) begin
      li_old[i] = 16'($urandom_range(0, 3000));
      li_new[i] = $urandom_range(0, 7) == 0 ? 16'd0 : 16'($urandom_range(1, 3000));
      mi_old[i] = 8'($urandom);
      mi_new[i] = 8'($urandom);
    end
  endtask

  task automatic start_job(input logic f);
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < TIL; i++)
      x.c[8*i+:8] = f ? 8'd0 : 8'(model(int'(li_old[i]), int'($signed(mi_old[i])),
                                          int'(li_new[i]), int'($signed(mi_new[i]))));
    x.at = cyc + 1 + (f ? 1 : N_NORM);
    sb.push_back(x);
    start = 1'b1;
    first = f;
    @(posedge clk);
    #1 start = 1'b0;
    first = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check("vld_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_vld"}, vld, 0);
    for (int i = 0; i < TIL; i++) check($sformatf("%s_coef[%0d]", tag, i), coef[i], 0);
  endtask

  initial begin
    fill(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    fill(256, 256, 0, 0);
    start_job(1'b0);
    wait_done();

    fill(128, 256, 0, 0);
    li_new[5] = 16'd0;
    start_job(1'b0);
    wait_done();

    fill_rand();
    start_job(1'b1);
    check("first_busy_e0", busy, 1);
    @(posedge clk);
    #1 check("first_busy_e1", busy, 1);
    @(posedge clk);
    #1 check("first_busy_e2", busy, 0);
    wait_done();

    fill_rand();
    start_job(1'b0);
    fill_rand();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #1 start = 1'b1;
    first = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);

    fill_rand();
    li_old[0] = 16'd200; li_new[0] = 16'd200; mi_old[0] = 8'd10; mi_new[0] = 8'd2;
    li_old[1] = 16'd200; li_new[1] = 16'd200; mi_old[1] = 8'h80; mi_new[1] = 8'd127;
    li_old[2] = 16'd300; li_new[2] = 16'd300; mi_old[2] = 8'hFE; mi_new[2] = 8'd0;
    li_old[3] = 16'd900; li_new[3] = 16'd100; mi_old[3] = 8'd5; mi_new[3] = 8'd5;
    start_job(1'b0);
    wait_done();

    for (int j = 0; j < 3; j++) begin
      fill_rand();
      start_job(1'b0);
      wait_done();
    end

    fill(100, 50, 3, 4);
    start_job(1'b0);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1 check_idle_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    fill(256, 256, 0, 0);
    start_job(1'b0);
    wait_done();

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
